// File: rtl/ps2_scancode_parser.sv
// PS/2 set-2 byte stream to key events: keyCode plus make/brakee pulses.
// In: clk, resetN, din[7:0], din_new. Out: keyCode[8:0], make, brakee, seq_err.
module ps2_scancode_parser #(
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [8:0] PAUSE_CODE     = 9'h1E1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] din,
  input  logic       din_new,
  output logic [8:0] keyCode,
  output logic       make,
  output logic       brakee,
  output logic       seq_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, EXT, BRK, EXT_BRK, PAUSE
  } state_t;

  state_t      state_q, state_d;
  logic [TW-1:0] to_q, to_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [8:0]  key_q, key_d;
  logic        make_q, make_d;
  logic        brk_q, brk_d;
  logic        err_q, err_d;

  logic is_e0, is_f0, is_e1, is_12;
  logic is_stat, is_pfx, timeout;

  assign is_e0 = (din == 8'hE0);
  assign is_f0 = (din == 8'hF0);
  assign is_e1 = (din == 8'hE1);
  assign is_12 = (din == 8'h12);
  assign is_stat = (din == 8'hAA) || (din == 8'hFA) ||
                   (din == 8'hFE) || (din == 8'hEE) ||
                   (din == 8'h00) || (din == 8'hFF);
  assign is_pfx = is_e0 || is_f0 || is_e1;

  // An arriving byte beats the timeout on the same clk.
  assign timeout = (to_q == TO_MAX) && !din_new;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      to_q    <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      make_q  <= 1'b0;
      brk_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      make_q  <= make_d;
      brk_q   <= brk_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (din_new) begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            is_e0:   state_d = EXT;
            is_f0:   state_d = BRK;
            is_e1: begin
              state_d = PAUSE;
              cnt_d   = 3'd1;
            end
            default: state_d = IDLE;
          endcase
        end
        EXT: begin
          unique case (1'b1)
            is_f0:   state_d = EXT_BRK;
            is_e0:   state_d = EXT;
            default: state_d = IDLE;
          endcase
        end
        PAUSE: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout && state_q != IDLE) begin
      state_d = IDLE;
    end
    if (state_d != PAUSE) cnt_d = '0;

    if (din_new || state_q == IDLE) to_d = '0;
    else if (to_q != TO_MAX)        to_d = to_q + 1'b1;
    else                            to_d = to_q;
  end

  always_comb begin
    make_d = 1'b0;
    brk_d  = 1'b0;
    err_d  = 1'b0;
    key_d  = key_q;
    if (din_new) begin
      unique case (state_q)
        IDLE: begin
          if (!is_pfx && !is_stat) begin
            make_d = 1'b1;
            key_d  = {1'b0, din};
          end
        end
        EXT: begin
          unique case (1'b1)
            is_f0, is_e0, is_12: ;
            is_e1, is_stat:      err_d = 1'b1;
            default: begin
              make_d = 1'b1;
              key_d  = {1'b1, din};
            end
          endcase
        end
        BRK: begin
          if (is_pfx || is_stat) err_d = 1'b1;
          else begin
            brk_d = 1'b1;
            key_d = {1'b0, din};
          end
        end
        EXT_BRK: begin
          unique case (1'b1)
            is_12:           ;
            is_pfx, is_stat: err_d = 1'b1;
            default: begin
              brk_d = 1'b1;
              key_d = {1'b1, din};
            end
          endcase
        end
        PAUSE: begin
          if (cnt_q == 3'd7) begin
            make_d = 1'b1;
            key_d  = PAUSE_CODE;
          end
        end
        default: ;
      endcase
    end
  end

  assign keyCode = key_q;
  assign make    = make_q;
  assign brakee  = brk_q;
  assign seq_err = err_q;

endmodule

// File: tb/tb_ps2_scancode_parser.sv
// Directed bench for ps2_scancode_parser.
// Small timeout so the expiry boundary is cheap to reach.
module tb_ps2_scancode_parser;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_new = 1'b0;
  logic [8:0] keyCode;
  logic       make, brakee, seq_err;

  int pass_n = 0;
  int total_n = 0;
  int n_make = 0;
  int n_brk = 0;
  int n_err = 0;

  ps2_scancode_parser #(
    .TIMEOUT_CYCLES(T),
    .PAUSE_CODE(9'h1E1)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .din(din),
    .din_new(din_new),
    .keyCode(keyCode),
    .make(make),
    .brakee(brakee),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (make)    n_make++;
    if (brakee)  n_brk++;
    if (seq_err) n_err++;
  end

  task automatic send(input logic [7:0] b);
    din = b;
    din_new = 1'b1;
    @(posedge clk);
    #1;
    din_new = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_make = 0;
    n_brk = 0;
    n_err = 0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    idle(3);
    total_n++;
    if ({keyCode, make, brakee, seq_err} !== 12'h000)
      $display("FAIL reset_outs got=%h exp=000",
               {keyCode, make, brakee, seq_err});
    else pass_n++;
    resetN = 1'b1;
    idle(2);
  endtask

  task automatic test_make();
    send(8'h29);
    total_n++;
    if (make !== 1'b1 || keyCode !== 9'h029 || brakee !== 1'b0)
      $display("FAIL make_29 make=%b key=%h brk=%b exp 1/029/0",
               make, keyCode, brakee);
    else pass_n++;
    idle(1);
    total_n++;
    if (make !== 1'b0)
      $display("FAIL make_pulse_width make=%b exp=0", make);
    else pass_n++;
  endtask

  task automatic test_break();
    clr();
    send(8'hF0);
    send(8'h29);
    total_n++;
    if (brakee !== 1'b1 || keyCode !== 9'h029 || make !== 1'b0)
      $display("FAIL brk_29 brk=%b key=%h make=%b exp 1/029/0",
               brakee, keyCode, make);
    else pass_n++;
    idle(2);
    total_n++;
    if (n_make != 0 || n_brk != 1)
      $display("FAIL brk_count makes=%0d brks=%0d exp 0/1",
               n_make, n_brk);
    else pass_n++;
  endtask

  task automatic test_ext();
    send(8'hE0);
    send(8'h75);
    total_n++;
    if (make !== 1'b1 || keyCode !== 9'h175)
      $display("FAIL ext_make make=%b key=%h exp 1/175",
               make, keyCode);
    else pass_n++;
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    total_n++;
    if (brakee !== 1'b1 || keyCode !== 9'h175)
      $display("FAIL ext_brk brk=%b key=%h exp 1/175",
               brakee, keyCode);
    else pass_n++;
    idle(1);
    clr();
    send(8'hE0);
    send(8'h12);
    send(8'hE0);
    send(8'hF0);
    send(8'h12);
    idle(2);
    total_n++;
    if (n_make + n_brk + n_err != 0 || keyCode !== 9'h175)
      $display("FAIL fake_shift events=%0d key=%h exp 0/175",
               n_make + n_brk + n_err, keyCode);
    else pass_n++;
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1,
            8'hF0, 8'h14, 8'hF0, 8'h77};
    clr();
    for (int i = 0; i < 7; i++) send(seq[i]);
    total_n++;
    if (n_make + n_brk + n_err != 0)
      $display("FAIL pause_early events=%0d exp=0",
               n_make + n_brk + n_err);
    else pass_n++;
    send(seq[7]);
    total_n++;
    if (make !== 1'b1 || keyCode !== 9'h1E1)
      $display("FAIL pause_make make=%b key=%h exp 1/1e1",
               make, keyCode);
    else pass_n++;
    idle(2);
    total_n++;
    if (n_make != 1 || n_brk != 0 || n_err != 0)
      $display("FAIL pause_count m=%0d b=%0d e=%0d exp 1/0/0",
               n_make, n_brk, n_err);
    else pass_n++;
  endtask

  task automatic test_timeout();
    send(8'hE0);
    idle(T - 1);
    send(8'h75);
    total_n++;
    if (make !== 1'b1 || keyCode !== 9'h175)
      $display("FAIL timeout_edge make=%b key=%h exp 1/175",
               make, keyCode);
    else pass_n++;
    idle(1);
    clr();
    send(8'hE0);
    idle(T);
    send(8'h29);
    total_n++;
    if (make !== 1'b1 || keyCode !== 9'h029)
      $display("FAIL timeout_expire make=%b key=%h exp 1/029",
               make, keyCode);
    else pass_n++;
    total_n++;
    if (n_err != 0)
      $display("FAIL timeout_noerr errs=%0d exp=0", n_err);
    else pass_n++;
    idle(1);
  endtask

  task automatic test_seq_err();
    clr();
    send(8'hF0);
    send(8'hF0);
    total_n++;
    if (seq_err !== 1'b1 || brakee !== 1'b0)
      $display("FAIL seq_err_ff err=%b brk=%b exp 1/0",
               seq_err, brakee);
    else pass_n++;
    send(8'hFA);
    total_n++;
    if (seq_err !== 1'b0)
      $display("FAIL seq_err_width err=%b exp=0", seq_err);
    else pass_n++;
    send(8'hAA);
    idle(2);
    total_n++;
    if (n_err != 1 || n_make != 0 || n_brk != 0)
      $display("FAIL status_ignored e=%0d m=%0d b=%0d exp 1/0/0",
               n_err, n_make, n_brk);
    else pass_n++;
  endtask

  task automatic test_reset_mid();
    send(8'hE0);
    #2;
    resetN = 1'b0;
    #1;
    total_n++;
    if (keyCode !== 9'h000 || make !== 1'b0)
      $display("FAIL async_reset key=%h make=%b exp 000/0",
               keyCode, make);
    else pass_n++;
    idle(2);
    resetN = 1'b1;
    clr();
    idle(2);
    send(8'h29);
    total_n++;
    if (make !== 1'b1 || keyCode !== 9'h029)
      $display("FAIL reset_mid_make make=%b key=%h exp 1/029",
               make, keyCode);
    else pass_n++;
    idle(1);
    total_n++;
    if (n_make != 1 || n_brk != 0 || n_err != 0)
      $display("FAIL reset_mid_count m=%0d b=%0d e=%0d exp 1/0/0",
               n_make, n_brk, n_err);
    else pass_n++;
  endtask

  task automatic test_back_to_back();
    clr();
    send(8'h29);
    send(8'hF0);
    send(8'h29);
    send(8'hE0);
    send(8'h1C);
    idle(2);
    total_n++;
    if (n_make != 2 || n_brk != 1 || n_err != 0)
      $display("FAIL b2b_count m=%0d b=%0d e=%0d exp 2/1/0",
               n_make, n_brk, n_err);
    else pass_n++;
    total_n++;
    if (keyCode !== 9'h11C)
      $display("FAIL b2b_key key=%h exp=11c", keyCode);
    else pass_n++;
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext();
    test_pause();
    test_timeout();
    test_seq_err();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
